// File: rtl/packet_checker_sequence_pkg.sv
// rtl/packet_checker_sequence_pkg.sv - shared byte-size and CRC-8 helpers for the link frame path
package packet_checker_sequence_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   function automatic int fun_sizeof_byte(input int width);
      return (width + 7) / 8;
   endfunction

   // MSB-first, no reflection, no final xor; shared with the TX CRC appender
   function automatic logic [7:0] fun_crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// rtl/crc8_byte_update.sv - combinational next-CRC for one byte
module crc8_byte_update
   import packet_checker_sequence_pkg::*;
(
   input  logic [7:0] crc,
   input  logic [7:0] data_byte,
   output logic [7:0] crc_next
);

   assign crc_next = fun_crc8_byte(crc, data_byte);

endmodule

// File: rtl/packet_checker_sequence.sv
// rtl/packet_checker_sequence.sv - frame assembler with CRC-8 and ID sequence check, ACK/NACK generation
module packet_checker_sequence
   import packet_checker_sequence_pkg::*;
#(
   parameter int FRAME_WIDTH = 56,
   parameter int ID_WIDTH    = 3
) (
   input  logic                   i_clk,
   input  logic                   i_arst_n,
   input  logic                   i_sop,
   input  logic                   i_byte_valid,
   input  logic [7:0]             i_byte,
   output logic [FRAME_WIDTH-1:0] o_data,
   output logic                   o_data_valid,
   output logic                   o_resp_valid,
   output logic                   o_resp_nack,
   output logic [ID_WIDTH-1:0]    o_resp_id,
   input  logic                   i_resp_ready,
   output logic                   o_err_crc,
   output logic                   o_err_seq
);

   localparam int FRAME_BYTES = fun_sizeof_byte(FRAME_WIDTH);
   localparam int CNT_WIDTH   = $clog2(FRAME_BYTES + 1);
   localparam int BUF_WIDTH   = FRAME_BYTES * 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CRC   = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   state_t                r_state, w_state_next;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [7:0]            r_crc, w_crc_in, w_crc_next;
   logic [BUF_WIDTH-1:0]  r_buf;
   logic [ID_WIDTH-1:0]   r_id, r_exp_id, r_last_id, w_exp_prev;
   logic                  r_nack_sent;

   logic                  w_hdr, w_crc_byte;
   logic                  w_accept, w_err_crc, w_err_seq;
   logic                  w_resp_load, w_resp_nack;
   logic [ID_WIDTH-1:0]   w_resp_id;

   // a valid sop restarts framing from any state, aborting a partial frame silently
   assign w_hdr      = i_sop && i_byte_valid;
   assign w_crc_byte = (r_state == ST_CRC) && i_byte_valid && !i_sop;
   assign w_exp_prev = r_exp_id - 1'b1;
   assign w_crc_in   = w_hdr ? 8'h00 : r_crc;

   crc8_byte_update u_crc (
      .crc       (w_crc_in),
      .data_byte (i_byte),
      .crc_next  (w_crc_next)
   );

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_hdr) begin
         w_state_next = ST_DATA;
      end else begin
         unique case (r_state)
            ST_IDLE:  w_state_next = ST_IDLE;
            ST_DATA:  if (i_byte_valid && r_cnt == CNT_WIDTH'(FRAME_BYTES - 1)) w_state_next = ST_CRC;
            ST_CRC:   if (i_byte_valid) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // frame verdict is taken on the CRC byte so pulses and response show in the CHECK cycle
   always_comb begin
      w_accept    = 1'b0;
      w_err_crc   = 1'b0;
      w_err_seq   = 1'b0;
      w_resp_load = 1'b0;
      w_resp_nack = 1'b0;
      w_resp_id   = r_exp_id;
      if (w_crc_byte) begin
         if (i_byte != r_crc) begin
            w_err_crc   = 1'b1;
            w_resp_load = !r_nack_sent;
            w_resp_nack = 1'b1;
         end else if (r_id == r_exp_id) begin
            w_accept    = 1'b1;
            w_resp_load = 1'b1;
            w_resp_id   = r_id;
         end else if (r_id == w_exp_prev) begin
            w_resp_load = 1'b1;
            w_resp_id   = r_last_id;
         end else begin
            w_err_seq   = 1'b1;
            w_resp_load = !r_nack_sent;
            w_resp_nack = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_cnt        <= '0;
         r_crc        <= '0;
         r_buf        <= '0;
         r_id         <= '0;
         r_exp_id     <= '0;
         r_last_id    <= '1;
         r_nack_sent  <= 1'b0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_err_crc    <= 1'b0;
         o_err_seq    <= 1'b0;
         o_resp_valid <= 1'b0;
         o_resp_nack  <= 1'b0;
         o_resp_id    <= '0;
      end else begin
         if (w_hdr) begin
            r_cnt <= '0;
            r_crc <= w_crc_next;
            r_id  <= i_byte[ID_WIDTH-1:0];
         end else if (r_state == ST_DATA && i_byte_valid) begin
            r_cnt <= r_cnt + 1'b1;
            r_crc <= w_crc_next;
            r_buf <= {i_byte, r_buf[BUF_WIDTH-1:8]};
         end

         o_data_valid <= w_accept;
         o_err_crc    <= w_err_crc;
         o_err_seq    <= w_err_seq;

         if (w_accept) begin
            o_data      <= r_buf[FRAME_WIDTH-1:0];
            r_exp_id    <= r_exp_id + 1'b1;
            r_last_id   <= r_id;
            r_nack_sent <= 1'b0;
         end else if (w_err_crc || w_err_seq) begin
            r_nack_sent <= 1'b1;
         end

         // latest response wins, even over a handshake in the same cycle
         if (w_resp_load) begin
            o_resp_valid <= 1'b1;
            o_resp_nack  <= w_resp_nack;
            o_resp_id    <= w_resp_id;
         end else if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
         end
      end
   end

endmodule
